diff_reconstruct: RTL and testbench
===================================

# diff_reconstruct

Sequential decoder for the bit-difference index stream produced by `diff_operator`. That encoder emits the index of the lowest differing bit between two 32-bit words, with 32 meaning "no difference". This block loads a base word and accepts a strictly ascending stream of indices over a valid/ready handshake, toggling one bit per index. On receiving the terminator index 32 it presents the reconstructed word. It sits on the receive side of the difference-compression path, one stream per reconstruction.

## Interface
Parameters: none (word width fixed at 32, index width fixed at 6).

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `load`  in  1  — start a reconstruction; sampled every cycle.
- `base`  in  32  — base word, captured when `load`=1.
- `idx_valid`  in  1  — `idx` is valid.
- `idx`  in  6  — meaning of each value:
  - 0–31: bit to toggle.
  - 32: terminator.
  - 33–63: illegal.
- `idx_ready`  out  1  — block accepts `idx` this cycle.
- `word`  out  32  — last completed reconstruction; held until the next completion.
- `flips`  out  6  — number of bits toggled in the last completed reconstruction (0–32).
- `done`  out  1  — one-cycle pulse; `word`/`flips` updated this cycle.
- `err`  out  1  — sticky protocol-error flag, cleared by `load`.
- `busy`  out  1  — reconstruction in progress.

## Operation
- Internal state:
  - `acc` [31:0]: accumulator.
  - `min_idx` [5:0]: lowest legal next index.
  - `cnt` [5:0]: toggle count.
  - `state` ∈ {IDLE, ACCUM}.
- Handshake: a transfer occurs on a rising edge with `idx_valid`=1 and `idx_ready`=1. `idx_ready` = (state==ACCUM) && !`load`.
- IDLE:
  - `idx_ready`=0; `idx_valid` is ignored.
  - `load`=1 → `acc`←`base`, `min_idx`←0, `cnt`←0, `err`←0, go to ACCUM.
- ACCUM, `load`=1: abort and restart exactly as from IDLE. `load` has priority; any simultaneous `idx` is not accepted.
- ACCUM, transfer with `idx`==32:
  - `word`←`acc`, `flips`←`cnt`, `done`←1 next cycle, go to IDLE.
  - The terminator is legal at any `min_idx`.
- ACCUM, transfer with `idx`<32 and `idx`≥`min_idx`:
  - `acc[idx]`←~`acc[idx]`, `min_idx`←`idx`+1, `cnt`←`cnt`+1.
- ACCUM, transfer with `idx`>32 or `idx`<`min_idx`:
  - `err`←1; the index is consumed and discarded.
  - `acc`, `min_idx` and `cnt` are unchanged; stay in ACCUM.
- After accepting `idx`=31, `min_idx`=32. Only the terminator is then legal; any other index sets `err`.
- `cnt` is at most 32 and never wraps, because ascending order bounds toggles to 32.
- `err` stays set through completion and into IDLE. It is cleared only by `load` or `rst`.
- `busy` = (state==ACCUM).

## Timing
- Reset values:
  - state=IDLE, `acc`=0, `min_idx`=0, `cnt`=0.
  - `word`=0, `flips`=0, `done`=0, `err`=0, `busy`=0, `idx_ready`=0.
- `rst` mid-reconstruction discards all progress immediately (asynchronous). `word`/`flips` return to 0.
- All outputs are registered except `idx_ready`, which is combinational from state and `load`.
- `load` in cycle N → `busy`=1 and `idx_ready`=1 in cycle N+1 (if `load` is deasserted).
- Throughput: one index per cycle, with no bubbles.
- Terminator accepted at edge N → `done`=1 and `word`/`flips` valid during cycle N+1. `busy`=0 in the same cycle.
- Earliest next `load` is cycle N+1; back-to-back reconstructions are allowed.
- `done` is a one-cycle pulse and never asserts on an abort or a reset.
- Minimum reconstruction (load, then terminator): `done` 2 cycles after `load`.

## Test plan
- Equal words:
  - Stimulus: load `base`=0xDEADBEEF, then `idx`=32.
  - Response: `done` pulse, `word`=0xDEADBEEF, `flips`=0, `err`=0.
- Typical stream:
  - Stimulus: load `base`=0x00000000, stream 0, 4, 31, 32 with `idx_valid` held high.
  - Response: `word`=0x80000011, `flips`=3, `done` exactly 1 cycle after terminator acceptance, `idx_ready` continuously 1.
- Order and range errors:
  - Stimulus: load 0x0000FFFF, stream 8, 3, 40, 8, 32.
  - Response: `err`=1 after the 3.
  - Response: `word`=0x0000FEFF, `flips`=1, `err` still 1 at `done`.
  - Response: next `load` clears `err`.
- Full word:
  - Stimulus: load 0x00000000, stream 0..31 ascending, then 32.
  - Response: `word`=0xFFFFFFFF, `flips`=32.
  - Follow-up: a second run sending 31, then 5 → `err`=1.
- Abort and priority:
  - Stimulus: mid-stream assert `load` (`base`=0x12345678) while `idx_valid`=1 with `idx`=2.
  - Response: `idx_ready`=0 in that cycle, the index is not consumed, no `done`.
  - Response: the new run with terminator gives `word`=0x12345678.
- Async reset:
  - Stimulus: assert `rst` between edges in mid-ACCUM.
  - Response: all outputs go to 0 immediately; no `done` after release.
  - Response: `idx_valid` is ignored until the next `load`.

Source files
------------

// File: rtl/diff_reconstruct_if.sv
// Handshake and result bundle for diff_reconstruct: index stream in,
// reconstructed word, toggle count and status out.
interface diff_reconstruct_if;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned IDX_W  = 6;

    logic              load;
    logic [WORD_W-1:0] base;
    logic              idx_valid;
    logic [IDX_W-1:0]  idx;
    logic              idx_ready;
    logic [WORD_W-1:0] word;
    logic [IDX_W-1:0]  flips;
    logic              done;
    logic              err;
    logic              busy;

    modport master (
        output load, base, idx_valid, idx,
        input  idx_ready, word, flips, done, err, busy
    );

    modport slave (
        input  load, base, idx_valid, idx,
        output idx_ready, word, flips, done, err, busy
    );
endinterface

// File: rtl/diff_reconstruct.sv
// Rebuilds a 32-bit word from a base and a strictly ascending stream of
// bit-toggle indices terminated by index 32.
module diff_reconstruct (
    input  logic              clk,
    input  logic              rst,
    diff_reconstruct_if.slave bus
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned BIT_W  = 5;
    localparam logic [IDX_W-1:0] TERM = IDX_W'(32);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t              state, state_nxt;
    logic [WORD_W-1:0]   acc, acc_nxt;
    logic [IDX_W-1:0]    min_idx, min_idx_nxt;
    logic [IDX_W-1:0]    cnt, cnt_nxt;
    logic [WORD_W-1:0]   word_nxt;
    logic [IDX_W-1:0]    flips_nxt;
    logic                done_nxt;
    logic                err_nxt;
    logic                xfer;
    logic [BIT_W-1:0]    bit_sel;

    // load takes priority over any index offered in the same cycle
    assign bus.idx_ready = (state == ACCUM) && !bus.load;
    assign bus.busy      = (state == ACCUM);
    assign xfer          = bus.idx_valid && bus.idx_ready;
    assign bit_sel       = bus.idx[BIT_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            min_idx   <= '0;
            cnt       <= '0;
            bus.word  <= '0;
            bus.flips <= '0;
            bus.done  <= 1'b0;
            bus.err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            min_idx   <= min_idx_nxt;
            cnt       <= cnt_nxt;
            bus.word  <= word_nxt;
            bus.flips <= flips_nxt;
            bus.done  <= done_nxt;
            bus.err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        acc_nxt     = acc;
        min_idx_nxt = min_idx;
        cnt_nxt     = cnt;
        word_nxt    = bus.word;
        flips_nxt   = bus.flips;
        done_nxt    = 1'b0;
        err_nxt     = bus.err;

        if (bus.load) begin
            state_nxt   = ACCUM;
            acc_nxt     = bus.base;
            min_idx_nxt = '0;
            cnt_nxt     = '0;
            err_nxt     = 1'b0;
        end else if (xfer) begin
            if (bus.idx == TERM) begin
                state_nxt = IDLE;
                word_nxt  = acc;
                flips_nxt = cnt;
                done_nxt  = 1'b1;
            end else if ((bus.idx < TERM) && (bus.idx >= min_idx)) begin
                acc_nxt[bit_sel] = ~acc[bit_sel];
                min_idx_nxt      = IDX_W'(bus.idx + IDX_W'(1));
                cnt_nxt          = IDX_W'(cnt + IDX_W'(1));
            end else begin
                // out-of-order or out-of-range index is consumed and dropped
                err_nxt = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_diff_reconstruct.sv
// Randomized and directed bench for diff_reconstruct against a queue-based
// model of each reconstruction run.
module tb_diff_reconstruct;
    logic clk = 1'b0;
    logic rst = 1'b1;

    diff_reconstruct_if bus ();

    diff_reconstruct dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // model: a run is its base plus the list of accepted indices
    logic [31:0] m_base;
    int          m_q[$];
    logic        m_busy;
    logic        m_err;
    logic        m_done;
    logic [31:0] m_word;
    logic [5:0]  m_flips;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic int next_min();
        return (m_q.size() == 0) ? 0 : m_q[$] + 1;
    endfunction

    function automatic logic [31:0] run_word();
        logic [31:0] w;
        w = m_base;
        foreach (m_q[i]) w = w ^ (32'h1 << m_q[i]);
        return w;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_base  = '0;
        m_busy  = 1'b0;
        m_err   = 1'b0;
        m_done  = 1'b0;
        m_word  = '0;
        m_flips = '0;
    endtask

    task automatic model_step(input logic ld, input logic [31:0] b, input logic v, input int ix);
        m_done = 1'b0;
        if (ld) begin
            m_base = b;
            m_q.delete();
            m_err  = 1'b0;
            m_busy = 1'b1;
        end else if (m_busy && v) begin
            if (ix == 32) begin
                m_word  = run_word();
                m_flips = 6'(m_q.size());
                m_done  = 1'b1;
                m_busy  = 1'b0;
            end else if (ix < 32 && ix >= next_min()) begin
                m_q.push_back(ix);
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        check("done",  32'(bus.done),  32'(m_done));
        check("word",  bus.word,       m_word);
        check("flips", 32'(bus.flips), 32'(m_flips));
        check("err",   32'(bus.err),   32'(m_err));
        check("busy",  32'(bus.busy),  32'(m_busy));
    endtask

    // one clock: drive, check ready, advance model across the edge, check state
    task automatic cycle(input logic ld, input logic [31:0] b, input logic v, input int ix);
        bus.load      = ld;
        bus.base      = b;
        bus.idx_valid = v;
        bus.idx       = 6'(ix);
        #1;
        check("idx_ready", 32'(bus.idx_ready), 32'(m_busy && !ld));
        @(posedge clk);
        model_step(ld, b, v, ix);
        #1;
        check_outputs();
    endtask

    task automatic run_stream(input logic [31:0] b, input int ids[$]);
        cycle(1'b1, b, 1'b0, 0);
        foreach (ids[i]) cycle(1'b0, '0, 1'b1, ids[i]);
    endtask

    initial begin
        int ids[$];
        model_reset();
        bus.load = 1'b0; bus.base = '0; bus.idx_valid = 1'b0; bus.idx = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_outputs();
        check("idx_ready_rst", 32'(bus.idx_ready), 32'h0);

        // idle: valid indices are ignored
        cycle(1'b0, '0, 1'b1, 32);
        cycle(1'b0, '0, 1'b1, 3);

        // equal words
        ids = '{32};
        run_stream(32'hDEADBEEF, ids);
        check("eq_word", bus.word, 32'hDEADBEEF);

        // typical stream
        ids = '{0, 4, 31, 32};
        run_stream(32'h0, ids);
        check("typ_word", bus.word, 32'h80000011);
        check("typ_flips", 32'(bus.flips), 32'd3);

        // order and range errors
        ids = '{8, 3, 40, 8, 32};
        run_stream(32'h0000FFFF, ids);
        check("ord_word", bus.word, 32'h0000FEFF);
        check("ord_err", 32'(bus.err), 32'h1);
        cycle(1'b1, 32'h1, 1'b0, 0);
        check("ord_clear", 32'(bus.err), 32'h0);
        cycle(1'b0, '0, 1'b1, 32);

        // full word, then 31 followed by 5
        ids.delete();
        for (int i = 0; i <= 32; i++) ids.push_back(i);
        run_stream(32'h0, ids);
        check("full_word", bus.word, 32'hFFFFFFFF);
        check("full_flips", 32'(bus.flips), 32'd32);
        ids = '{31, 5};
        run_stream(32'h0, ids);
        check("after31_err", 32'(bus.err), 32'h1);
        cycle(1'b0, '0, 1'b1, 32);

        // abort with load while an index is offered
        ids = '{1};
        run_stream(32'hA5A5A5A5, ids);
        cycle(1'b1, 32'h12345678, 1'b1, 2);
        cycle(1'b0, '0, 1'b1, 32);
        check("abort_word", bus.word, 32'h12345678);

        // async reset mid-run, with err set and a nonzero held word
        ids = '{7, 2, 9};
        run_stream(32'hCAFEF00D, ids);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check("idx_ready_arst", 32'(bus.idx_ready), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        cycle(1'b0, '0, 1'b1, 32);
        cycle(1'b0, '0, 1'b1, 0);

        // randomized runs with gaps, illegal indices and aborts
        for (int r = 0; r < 150; r++) begin
            cycle(1'b1, $urandom, 1'b0, 0);
            for (int s = 0; s < 45 && m_busy; s++) begin
                int sel, ix, mn;
                sel = $urandom_range(0, 99);
                mn  = next_min();
                if (sel < 3)
                    cycle(1'b1, $urandom, 1'b1, $urandom_range(0, 63));
                else if (sel < 15)
                    cycle(1'b0, '0, 1'b0, $urandom_range(0, 63));
                else if (sel < 23)
                    cycle(1'b0, '0, 1'b1, $urandom_range(0, 63));
                else begin
                    ix = (mn >= 32 || sel >= 92) ? 32 : $urandom_range(mn, 31);
                    cycle(1'b0, '0, 1'b1, ix);
                end
            end
            if (m_busy) cycle(1'b0, '0, 1'b1, 32);
            if ($urandom_range(0, 3) == 0) cycle(1'b0, '0, 1'b1, $urandom_range(0, 63));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
